sc_statemachine_multi: RTL and testbench

//  Parametrised N-channel command sequencer: turns held active-low button/command levels into

---
 rtl/sc_statemachine_pkg.sv | 23 ++
 rtl/sc_repeat_timer.sv | 33 +++
 rtl/sc_statemachine_multi.sv | 164 ++++++++++++++++
 tb/tb_sc_statemachine_multi.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sc_statemachine_pkg.sv
// Shared definitions for the N-channel command sequencer.
//   scState_t : FSM state encodings
//   scClog2   : ceiling log2 used to size the latched-index register
package sc_statemachine_pkg;

   typedef enum logic [2:0] {
      stReset = 3'd0,
      stStart = 3'd1,
      stCheck = 3'd2,
      stPulse = 3'd3,
      stHold  = 3'd4
   } scState_t;

   function automatic int scClog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sc_repeat_timer.sv
// Saturating down-counter used for both the repeat delay/period and the pulse length.
//   SC_STATEMACHINE_CLOCK_50     in  system clock, rising edge
//   SC_STATEMACHINE_RESET_InHigh in  asynchronous active-high reset, clears the count
//   load                         in  load loadValue this cycle (wins over enable)
//   loadValue                    in  CNT_W value to load
//   enable                       in  decrement by one, stopping at zero
//   expired                      out count has reached zero
module sc_repeat_timer #(
   parameter int CNT_W = 25
) (
   input  logic             SC_STATEMACHINE_CLOCK_50,
   input  logic             SC_STATEMACHINE_RESET_InHigh,
   input  logic             load,
   input  logic [CNT_W-1:0] loadValue,
   input  logic             enable,
   output logic             expired
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge SC_STATEMACHINE_CLOCK_50 or posedge SC_STATEMACHINE_RESET_InHigh) begin
      if (SC_STATEMACHINE_RESET_InHigh) begin
         count <= '0;
      end else if (load) begin
         count <= loadValue;
      end else if (enable && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/sc_statemachine_multi.sv
// N-channel command sequencer: converts held active-low command levels into active-low
// one-shot pulses of PULSE_LEN cycles, with optional auto-repeat while the channel is held.
//   SC_STATEMACHINE_CLOCK_50     in  system clock, 50 MHz
//   SC_STATEMACHINE_RESET_InHigh in  asynchronous active-high reset
//   SC_STATEMACHINE_cmd_InLow    in  NCH command levels, active low, synchronised
//   SC_STATEMACHINE_cmd_OutLow   out NCH command pulses, active low, at most one low
//   SC_STATEMACHINE_busy_Out     out high in every state except CHECK
//   SC_STATEMACHINE_idx_Out      out index of the latched channel
//
// state | meaning
// RESET | entered on reset, outputs idle, busy
// START | one settling cycle before sampling commands
// CHECK | waiting for a command; only non-busy state
// PULSE | latched channel output driven low for PULSE_LEN cycles
// HOLD  | waiting for release or repeat-timer expiry
module sc_statemachine_multi
   import sc_statemachine_pkg::*;
#(
   parameter int NCH           = 4,
   parameter int PULSE_LEN     = 1,
   parameter int REPEAT_EN     = 0,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 5000000,
   parameter int CNT_W         = 25,
   localparam int IDX_W        = (NCH > 1) ? scClog2(NCH) : 1
) (
   input  logic             SC_STATEMACHINE_CLOCK_50,
   input  logic             SC_STATEMACHINE_RESET_InHigh,
   input  logic [NCH-1:0]   SC_STATEMACHINE_cmd_InLow,
   output logic [NCH-1:0]   SC_STATEMACHINE_cmd_OutLow,
   output logic             SC_STATEMACHINE_busy_Out,
   output logic [IDX_W-1:0] SC_STATEMACHINE_idx_Out
);

   // Timers count down to zero, so loading N-1 gives exactly N cycles in the state.
   localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_LEN - 1);
   localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);

   scState_t         state, stateNext;
   logic [IDX_W-1:0] idx, idxNext;
   logic             first, firstNext;

   logic             anyLow;
   logic [IDX_W-1:0] lowestIdx;
   logic             latchedHeld;

   logic             pulseLoad, pulseEnable, pulseExpired;
   logic             repLoad, repEnable, repExpired;
   logic [CNT_W-1:0] repLoadValue;

   // Priority encode: scan high to low so the lowest low bit wins.
   always_comb begin
      anyLow    = 1'b0;
      lowestIdx = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (!SC_STATEMACHINE_cmd_InLow[i]) begin
            anyLow    = 1'b1;
            lowestIdx = IDX_W'(i);
         end
      end
   end

   // Compare-based select keeps the lookup in range for non power-of-two NCH.
   always_comb begin
      latchedHeld = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (IDX_W'(i) == idx) begin
            latchedHeld = !SC_STATEMACHINE_cmd_InLow[i];
         end
      end
   end

   always_comb begin
      stateNext    = state;
      idxNext      = idx;
      firstNext    = first;
      pulseLoad    = 1'b0;
      pulseEnable  = 1'b0;
      repLoad      = 1'b0;
      repEnable    = 1'b0;
      repLoadValue = DELAY_LOAD;
      case (state)
         stReset: stateNext = stStart;
         stStart: stateNext = stCheck;
         stCheck: begin
            if (anyLow) begin
               idxNext   = lowestIdx;
               firstNext = 1'b0;
               pulseLoad = 1'b1;
               stateNext = stPulse;
            end
         end
         stPulse: begin
            if (pulseExpired) begin
               repLoad      = 1'b1;
               repLoadValue = first ? PERIOD_LOAD : DELAY_LOAD;
               firstNext    = 1'b1;
               stateNext    = stHold;
            end else begin
               pulseEnable = 1'b1;
            end
         end
         stHold: begin
            // Release is checked first so it wins over a coincident expiry.
            if (!latchedHeld) begin
               stateNext = stCheck;
            end else if ((REPEAT_EN != 0) && repExpired) begin
               pulseLoad = 1'b1;
               stateNext = stPulse;
            end else begin
               repEnable = 1'b1;
            end
         end
         default: stateNext = stCheck;
      endcase
   end

   always_ff @(posedge SC_STATEMACHINE_CLOCK_50 or posedge SC_STATEMACHINE_RESET_InHigh) begin
      if (SC_STATEMACHINE_RESET_InHigh) begin
         state <= stReset;
         idx   <= '0;
         first <= 1'b0;
      end else begin
         state <= stateNext;
         idx   <= idxNext;
         first <= firstNext;
      end
   end

   sc_repeat_timer #(.CNT_W(CNT_W)) pulseTimer (
      .SC_STATEMACHINE_CLOCK_50     (SC_STATEMACHINE_CLOCK_50),
      .SC_STATEMACHINE_RESET_InHigh (SC_STATEMACHINE_RESET_InHigh),
      .load                         (pulseLoad),
      .loadValue                    (PULSE_LOAD),
      .enable                       (pulseEnable),
      .expired                      (pulseExpired)
   );

   sc_repeat_timer #(.CNT_W(CNT_W)) repeatTimer (
      .SC_STATEMACHINE_CLOCK_50     (SC_STATEMACHINE_CLOCK_50),
      .SC_STATEMACHINE_RESET_InHigh (SC_STATEMACHINE_RESET_InHigh),
      .load                         (repLoad),
      .loadValue                    (repLoadValue),
      .enable                       (repEnable),
      .expired                      (repExpired)
   );

   // Outputs decode only registered state and idx.
   always_comb begin
      SC_STATEMACHINE_cmd_OutLow = '1;
      if (state == stPulse) begin
         for (int i = 0; i < NCH; i++) begin
            if (IDX_W'(i) == idx) begin
               SC_STATEMACHINE_cmd_OutLow[i] = 1'b0;
            end
         end
      end
   end

   assign SC_STATEMACHINE_busy_Out = (state != stCheck);
   assign SC_STATEMACHINE_idx_Out  = idx;

endmodule

// File: tb/tb_sc_statemachine_multi.sv
module tb_sc_statemachine_multi;

   logic       clk;
   logic       rst;
   logic [3:0] cmdIn;
   logic [3:0] cmdOut;
   logic       busy;
   logic [1:0] idxOut;
   logic [3:0] cmdIn0;
   logic [3:0] cmdOut0;
   logic       busy0;
   logic [1:0] idxOut0;

   int nAsserts = 0;
   int nFail    = 0;

   sc_statemachine_multi #(
      .NCH(4), .PULSE_LEN(2), .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(4), .CNT_W(25)
   ) dut (
      .SC_STATEMACHINE_CLOCK_50     (clk),
      .SC_STATEMACHINE_RESET_InHigh (rst),
      .SC_STATEMACHINE_cmd_InLow    (cmdIn),
      .SC_STATEMACHINE_cmd_OutLow   (cmdOut),
      .SC_STATEMACHINE_busy_Out     (busy),
      .SC_STATEMACHINE_idx_Out      (idxOut)
   );

   sc_statemachine_multi #(
      .NCH(4), .PULSE_LEN(2), .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(4), .CNT_W(25)
   ) dutNoRep (
      .SC_STATEMACHINE_CLOCK_50     (clk),
      .SC_STATEMACHINE_RESET_InHigh (rst),
      .SC_STATEMACHINE_cmd_InLow    (cmdIn0),
      .SC_STATEMACHINE_cmd_OutLow   (cmdOut0),
      .SC_STATEMACHINE_busy_Out     (busy0),
      .SC_STATEMACHINE_idx_Out      (idxOut0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nAsserts++;
      assert (obs === expv)
      else begin
         nFail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   initial begin
      int lowCount;
      logic [3:0] expOut;

      rst    = 1'b1;
      cmdIn  = 4'b1111;
      cmdIn0 = 4'b1111;

      // 1: reset and start-up sequence
      tick();
      check("rst_out", 32'(cmdOut), 32'h000f);
      check("rst_busy", 32'(busy), 32'h1);
      check("rst_idx", 32'(idxOut), 32'h0);
      rst = 1'b0;
      tick();
      check("start_busy", 32'(busy), 32'h1);
      check("start_out", 32'(cmdOut), 32'h000f);
      tick();
      check("check_busy", 32'(busy), 32'h0);
      check("check_busy_norep", 32'(busy0), 32'h0);
      tick();
      check("idle_out", 32'(cmdOut), 32'h000f);

      // 2: single-cycle tap on ch2
      cmdIn = 4'b1011;
      tick();
      cmdIn = 4'b1111;
      check("tap_p1", 32'(cmdOut), 32'h000b);
      check("tap_idx", 32'(idxOut), 32'h2);
      check("tap_busy", 32'(busy), 32'h1);
      tick();
      check("tap_p2", 32'(cmdOut), 32'h000b);
      tick();
      check("tap_end", 32'(cmdOut), 32'h000f);
      check("tap_hold_busy", 32'(busy), 32'h1);
      tick();
      check("tap_back_check", 32'(busy), 32'h0);

      // 3: hold ch1 for 40 cycles; pulses at 0,12,18,24,30,36 each 2 cycles wide
      cmdIn = 4'b1101;
      for (int c = 0; c < 40; c++) begin
         tick();
         if ((c < 2) || ((c >= 12) && (((c - 12) % 6) < 2))) expOut = 4'b1101;
         else expOut = 4'b1111;
         check($sformatf("rep_c%0d", c), 32'(cmdOut), 32'(expOut));
      end
      cmdIn = 4'b1111;
      tick();
      check("rep_release_busy", 32'(busy), 32'h0);
      check("rep_release_out", 32'(cmdOut), 32'h000f);

      // 4: ch0 and ch3 together -> ch0 wins; ch3 fires after ch0 released
      cmdIn = 4'b0110;
      tick();
      check("prio_p1", 32'(cmdOut), 32'h000e);
      check("prio_idx", 32'(idxOut), 32'h0);
      cmdIn = 4'b0100;
      tick();
      check("prio_p2", 32'(cmdOut), 32'h000e);
      tick();
      check("prio_hold", 32'(cmdOut), 32'h000f);
      cmdIn = 4'b0111;
      tick();
      check("prio_check", 32'(busy), 32'h0);
      check("prio_check_out", 32'(cmdOut), 32'h000f);
      tick();
      check("ch3_p1", 32'(cmdOut), 32'h0007);
      check("ch3_idx", 32'(idxOut), 32'h3);
      cmdIn = 4'b1111;
      tick();
      check("ch3_p2", 32'(cmdOut), 32'h0007);
      tick();
      check("ch3_hold", 32'(cmdOut), 32'h000f);
      tick();
      check("ch3_done_busy", 32'(busy), 32'h0);
      tick();
      check("ch3_done_out", 32'(cmdOut), 32'h000f);

      // 5: reset mid-pulse releases output immediately
      cmdIn = 4'b1110;
      tick();
      check("mid_pulse", 32'(cmdOut), 32'h000e);
      rst = 1'b1;
      #1;
      check("mid_rst_out", 32'(cmdOut), 32'h000f);
      check("mid_rst_busy", 32'(busy), 32'h1);
      tick();
      check("mid_rst_held", 32'(cmdOut), 32'h000f);
      rst   = 1'b0;
      cmdIn = 4'b1111;
      tick();
      check("mid_start_busy", 32'(busy), 32'h1);
      check("mid_start_out", 32'(cmdOut), 32'h000f);
      tick();
      check("mid_check_busy", 32'(busy), 32'h0);

      // 6a: no-repeat instance, hold ch0 for 100 cycles -> one 2-cycle pulse
      cmdIn0   = 4'b1110;
      lowCount = 0;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (c < 2) check($sformatf("norep_p%0d", c), 32'(cmdOut0), 32'h000e);
         if (cmdOut0 != 4'b1111) lowCount++;
      end
      check("norep_low_cycles", 32'(lowCount), 32'd2);
      cmdIn0 = 4'b1111;
      tick();
      check("norep_release_busy", 32'(busy0), 32'h0);

      // 6b: release exactly at repeat-timer expiry -> no repeat
      cmdIn = 4'b1110;
      for (int c = 0; c < 12; c++) begin
         tick();
      end
      check("exp_in_hold", 32'(cmdOut), 32'h000f);
      check("exp_hold_busy", 32'(busy), 32'h1);
      cmdIn = 4'b1111;
      tick();
      check("exp_release_out", 32'(cmdOut), 32'h000f);
      check("exp_release_busy", 32'(busy), 32'h0);
      tick();
      check("exp_after_out", 32'(cmdOut), 32'h000f);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end

endmodule
